// File: rtl/wq_pkg.sv
// Shared sizing, slot/request state encodings and RR pointer helper for the wave queue fill controller.
package wq_pkg;
   localparam int NUM_WF  = 40;
   localparam int WF_ID_W = 6;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_READY,
      SLOT_PENDING,
      SLOT_IDLE_DRAIN
   } slot_state_t;

   typedef enum logic {
      REQ_IDLE,
      REQ_HOLD
   } req_state_t;

   function automatic logic [WF_ID_W-1:0] next_wf(input logic [WF_ID_W-1:0] id);
      return (id == WF_ID_W'(NUM_WF - 1)) ? '0 : id + 1'b1;
   endfunction
endpackage

// File: rtl/wq_rr_arbiter.sv
// Rotating-priority picker: first set request at or after start, wrapping N-1 -> 0.
// Purely combinational; caller owns the start pointer.
module wq_rr_arbiter
   import wq_pkg::*;
#(
   parameter int N    = NUM_WF,
   parameter int ID_W = WF_ID_W
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] start,
   output logic            gnt_vld,
   output logic [N-1:0]    gnt_onehot,
   output logic [ID_W-1:0] gnt_id
);
   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt_vld    = 1'b0;
      gnt_onehot = '0;
      gnt_id     = '0;
      sum        = '0;
      idx        = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, start} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
         idx = sum[ID_W-1:0];
         if (!gnt_vld && req[idx]) begin
            gnt_vld         = 1'b1;
            gnt_onehot[idx] = 1'b1;
            gnt_id          = idx;
         end
      end
   end
endmodule

// File: rtl/wq_fill_ctrl.sv
// Per-wavefront fetch PC tracking, RR fetch issue and queue write on return; request appears 1 cycle
// after pick and is held until fetch_gnt; stop_fetch only gates new picks, never a held request.
module wq_fill_ctrl
   import wq_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dispatch_vld,
   input  logic [WF_ID_W-1:0]         dispatch_wf_id,
   input  logic [PC_W-1:0]            dispatch_pc,
   input  logic                       redirect_vld,
   input  logic [WF_ID_W-1:0]         redirect_wf_id,
   input  logic [PC_W-1:0]            redirect_pc,
   input  logic                       halt_vld,
   input  logic [WF_ID_W-1:0]         halt_wf_id,
   input  logic [NUM_WF-1:0]          stop_fetch,
   output logic                       fetch_req,
   output logic [WF_ID_W-1:0]         fetch_req_wf_id,
   output logic [PC_W-1:0]            fetch_req_pc,
   input  logic                       fetch_gnt,
   input  logic                       fetch_ack,
   input  logic [WF_ID_W-1:0]         fetch_ack_wf_id,
   input  logic [INSTR_W-1:0]         fetch_ack_instr,
   output logic [NUM_WF-1:0]          q_wr,
   output logic [NUM_WF-1:0]          q_reset,
   output logic [INSTR_W+PC_W-1:0]    q_wr_data
);
   slot_state_t       slot_state [NUM_WF];
   logic [PC_W-1:0]   slot_pc    [NUM_WF];
   logic [NUM_WF-1:0] slot_discard;

   req_state_t         req_state, req_state_nxt;
   logic               pick;
   logic [WF_ID_W-1:0] rr_start;
   logic               held_dead;

   logic [NUM_WF-1:0]  eligible, halt_hit, redir_hit, ack_hit, disp_hit, held_live, gnt_hit;
   logic               arb_vld;
   logic [NUM_WF-1:0]  arb_onehot;
   logic [WF_ID_W-1:0] arb_id;
   logic [PC_W-1:0]    pick_pc;

   // A slot being halted or redirected this cycle must not be picked with its stale PC.
   always_comb begin
      eligible  = '0;
      halt_hit  = '0;
      redir_hit = '0;
      ack_hit   = '0;
      disp_hit  = '0;
      held_live = '0;
      gnt_hit   = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         halt_hit[i]  = halt_vld     && (halt_wf_id      == WF_ID_W'(i));
         redir_hit[i] = redirect_vld && (redirect_wf_id  == WF_ID_W'(i));
         ack_hit[i]   = fetch_ack    && (fetch_ack_wf_id == WF_ID_W'(i));
         disp_hit[i]  = dispatch_vld && (dispatch_wf_id  == WF_ID_W'(i));
         held_live[i] = (req_state == REQ_HOLD) && !held_dead && (fetch_req_wf_id == WF_ID_W'(i));
         gnt_hit[i]   = held_live[i] && fetch_gnt;
         eligible[i]  = (slot_state[i] == SLOT_READY) && !stop_fetch[i] && !halt_hit[i] && !redir_hit[i];
      end
   end

   wq_rr_arbiter #(.N(NUM_WF), .ID_W(WF_ID_W)) u_arb (
      .req        (eligible),
      .start      (rr_start),
      .gnt_vld    (arb_vld),
      .gnt_onehot (arb_onehot),
      .gnt_id     (arb_id)
   );

   always_comb begin
      pick_pc = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         if (arb_onehot[i]) pick_pc = pick_pc | slot_pc[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) req_state <= REQ_IDLE;
      else     req_state <= req_state_nxt;
   end

   always_comb begin
      req_state_nxt = req_state;
      pick          = 1'b0;
      case (req_state)
         REQ_IDLE: if (arb_vld) begin
            req_state_nxt = REQ_HOLD;
            pick          = 1'b1;
         end
         REQ_HOLD: if (fetch_gnt) req_state_nxt = REQ_IDLE;
         default:  req_state_nxt = REQ_IDLE;
      endcase
   end

   // held_dead marks a held request whose slot was halted: its grant must not touch the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_req       <= 1'b0;
         fetch_req_wf_id <= '0;
         fetch_req_pc    <= '0;
         rr_start        <= '0;
         held_dead       <= 1'b0;
      end else begin
         fetch_req <= (req_state_nxt == REQ_HOLD);
         if (pick) begin
            fetch_req_wf_id <= arb_id;
            fetch_req_pc    <= pick_pc;
            rr_start        <= next_wf(arb_id);
            held_dead       <= 1'b0;
         end else if (req_state == REQ_HOLD && halt_vld && halt_wf_id == fetch_req_wf_id) begin
            held_dead <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WF; i++) begin
            slot_state[i] <= SLOT_IDLE;
            slot_pc[i]    <= '0;
         end
         slot_discard <= '0;
         q_wr         <= '0;
         q_reset      <= '0;
         q_wr_data    <= '0;
      end else begin
         q_wr    <= '0;
         q_reset <= halt_hit | redir_hit;
         for (int i = 0; i < NUM_WF; i++) begin
            if (halt_hit[i]) begin
               // A fetch still in flight must drain before the slot can be reused.
               if ((slot_state[i] == SLOT_PENDING || slot_state[i] == SLOT_IDLE_DRAIN || gnt_hit[i])
                   && !ack_hit[i])
                  slot_state[i] <= SLOT_IDLE_DRAIN;
               else
                  slot_state[i] <= SLOT_IDLE;
               slot_discard[i] <= 1'b0;
            end else if (redir_hit[i]) begin
               slot_pc[i] <= redirect_pc;
               if (slot_state[i] == SLOT_PENDING && ack_hit[i]) begin
                  slot_state[i]   <= SLOT_READY;
                  slot_discard[i] <= 1'b0;
               end else if (slot_state[i] == SLOT_PENDING || held_live[i]) begin
                  slot_discard[i] <= 1'b1;
                  if (gnt_hit[i] && slot_state[i] == SLOT_READY) slot_state[i] <= SLOT_PENDING;
               end else if (slot_state[i] == SLOT_IDLE_DRAIN && ack_hit[i]) begin
                  slot_state[i] <= SLOT_IDLE;
               end
            end else begin
               if (gnt_hit[i] && slot_state[i] == SLOT_READY) slot_state[i] <= SLOT_PENDING;
               if (ack_hit[i]) begin
                  case (slot_state[i])
                     SLOT_PENDING: begin
                        slot_state[i]   <= SLOT_READY;
                        slot_discard[i] <= 1'b0;
                        if (!slot_discard[i]) begin
                           slot_pc[i] <= slot_pc[i] + PC_W'(4);
                           q_wr[i]    <= 1'b1;
                           q_wr_data  <= {fetch_ack_instr, slot_pc[i]};
                        end
                     end
                     SLOT_IDLE_DRAIN: begin
                        slot_state[i]   <= SLOT_IDLE;
                        slot_discard[i] <= 1'b0;
                     end
                     default: ;
                  endcase
               end
               if (disp_hit[i] && slot_state[i] == SLOT_IDLE) begin
                  slot_state[i]   <= SLOT_READY;
                  slot_pc[i]      <= dispatch_pc;
                  slot_discard[i] <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_wq_fill_ctrl.sv
// Directed bench for wq_fill_ctrl: queue writes are scoreboarded, requests and flushes checked inline.
module tb_wq_fill_ctrl;
   import wq_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    dispatch_vld;
   logic [WF_ID_W-1:0]      dispatch_wf_id;
   logic [PC_W-1:0]         dispatch_pc;
   logic                    redirect_vld;
   logic [WF_ID_W-1:0]      redirect_wf_id;
   logic [PC_W-1:0]         redirect_pc;
   logic                    halt_vld;
   logic [WF_ID_W-1:0]      halt_wf_id;
   logic [NUM_WF-1:0]       stop_fetch;
   logic                    fetch_req;
   logic [WF_ID_W-1:0]      fetch_req_wf_id;
   logic [PC_W-1:0]         fetch_req_pc;
   logic                    fetch_gnt;
   logic                    fetch_ack;
   logic [WF_ID_W-1:0]      fetch_ack_wf_id;
   logic [INSTR_W-1:0]      fetch_ack_instr;
   logic [NUM_WF-1:0]       q_wr;
   logic [NUM_WF-1:0]       q_reset;
   logic [INSTR_W+PC_W-1:0] q_wr_data;

   typedef struct packed {
      logic [WF_ID_W-1:0] id;
      logic [63:0]        data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   wq_fill_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .dispatch_vld    (dispatch_vld),
      .dispatch_wf_id  (dispatch_wf_id),
      .dispatch_pc     (dispatch_pc),
      .redirect_vld    (redirect_vld),
      .redirect_wf_id  (redirect_wf_id),
      .redirect_pc     (redirect_pc),
      .halt_vld        (halt_vld),
      .halt_wf_id      (halt_wf_id),
      .stop_fetch      (stop_fetch),
      .fetch_req       (fetch_req),
      .fetch_req_wf_id (fetch_req_wf_id),
      .fetch_req_pc    (fetch_req_pc),
      .fetch_gnt       (fetch_gnt),
      .fetch_ack       (fetch_ack),
      .fetch_ack_wf_id (fetch_ack_wf_id),
      .fetch_ack_instr (fetch_ack_instr),
      .q_wr            (q_wr),
      .q_reset         (q_reset),
      .q_wr_data       (q_wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_WF-1:0] oh(input int id);
      logic [NUM_WF-1:0] v;
      v = NUM_WF'(1) << id;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input int id, input logic [31:0] pc);
      dispatch_vld   = 1'b1;
      dispatch_wf_id = WF_ID_W'(id);
      dispatch_pc    = pc;
      tick();
      dispatch_vld   = 1'b0;
   endtask

   task automatic wait_req(input int id, input logic [31:0] pc, input int hold_cyc,
                           input int max_wait, input logic do_gnt);
      int n;
      n = 0;
      while (!fetch_req && n < max_wait) begin
         tick();
         n++;
      end
      chk("req_vld", 64'(fetch_req), 64'd1);
      chk("req_id", 64'(fetch_req_wf_id), 64'(id));
      chk("req_pc", 64'(fetch_req_pc), 64'(pc));
      for (int h = 0; h < hold_cyc; h++) begin
         tick();
         chk("req_held", {fetch_req, fetch_req_wf_id, fetch_req_pc}, {1'b1, WF_ID_W'(id), pc});
      end
      if (do_gnt) begin
         fetch_gnt = 1'b1;
         tick();
         fetch_gnt = 1'b0;
      end
   endtask

   task automatic do_ack(input int id, input logic [31:0] instr, input logic expect_wr,
                         input logic [31:0] pc);
      exp_t e;
      fetch_ack       = 1'b1;
      fetch_ack_wf_id = WF_ID_W'(id);
      fetch_ack_instr = instr;
      if (expect_wr) begin
         e.id   = WF_ID_W'(id);
         e.data = {instr, pc};
         sb.push_back(e);
      end
      tick();
      fetch_ack = 1'b0;
   endtask

   task automatic halt(input int id, input logic with_ack);
      halt_vld        = 1'b1;
      halt_wf_id      = WF_ID_W'(id);
      fetch_ack       = with_ack;
      fetch_ack_wf_id = WF_ID_W'(id);
      fetch_ack_instr = 32'h0BAD_0BAD;
      tick();
      halt_vld  = 1'b0;
      fetch_ack = 1'b0;
      chk("halt_q_reset", 64'(q_reset), 64'(oh(id)));
   endtask

   task automatic redirect(input int id, input logic [31:0] pc);
      redirect_vld   = 1'b1;
      redirect_wf_id = WF_ID_W'(id);
      redirect_pc    = pc;
      tick();
      redirect_vld   = 1'b0;
      chk("redirect_q_reset", 64'(q_reset), 64'(oh(id)));
   endtask

   // Every queue write must match the oldest outstanding expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst && q_wr != '0) begin
         if (sb.size() == 0) begin
            chk("q_wr_unexpected", 64'(q_wr), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("q_wr_strobe", 64'(q_wr), 64'(oh(int'(e.id))));
            chk("q_wr_data", q_wr_data, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      dispatch_vld = 1'b0; dispatch_wf_id = '0; dispatch_pc = '0;
      redirect_vld = 1'b0; redirect_wf_id = '0; redirect_pc = '0;
      halt_vld = 1'b0; halt_wf_id = '0; stop_fetch = '0;
      fetch_gnt = 1'b0; fetch_ack = 1'b0; fetch_ack_wf_id = '0; fetch_ack_instr = '0;
      repeat (3) tick();
      chk("rst_fetch_req", 64'(fetch_req), 64'd0);
      chk("rst_q_wr", 64'(q_wr), 64'd0);
      chk("rst_q_reset", 64'(q_reset), 64'd0);
      chk("rst_q_wr_data", q_wr_data, 64'd0);
      rst = 1'b0;
      tick();

      // basic fetch, grant one cycle after request, write and PC advance
      dispatch(3, 32'h100);
      wait_req(3, 32'h100, 1, 10, 1'b1);
      do_ack(3, 32'h0000_BEEF, 1'b1, 32'h100);
      wait_req(3, 32'h104, 0, 10, 1'b1);
      halt(3, 1'b0);
      do_ack(3, 32'h1234_5678, 1'b0, 32'h0);

      // round robin order with wrap
      dispatch(0, 32'h1000);
      dispatch(5, 32'h1000);
      dispatch(39, 32'h1000);
      wait_req(0, 32'h1000, 0, 10, 1'b1);
      wait_req(5, 32'h1000, 0, 10, 1'b1);
      wait_req(39, 32'h1000, 0, 10, 1'b1);
      do_ack(0, 32'hA0A0_0000, 1'b1, 32'h1000);
      wait_req(0, 32'h1004, 0, 10, 1'b1);
      halt(0, 1'b0);
      halt(5, 1'b0);
      halt(39, 1'b0);
      do_ack(0, 32'h1, 1'b0, 32'h0);
      do_ack(5, 32'h2, 1'b0, 32'h0);
      do_ack(39, 32'h3, 1'b0, 32'h0);

      // stop_fetch gating
      stop_fetch[5] = 1'b1;
      dispatch(5, 32'h500);
      repeat (6) tick();
      chk("stop_no_req", 64'(fetch_req), 64'd0);
      stop_fetch[5] = 1'b0;
      wait_req(5, 32'h500, 0, 2, 1'b1);
      do_ack(5, 32'hC5C5_C5C5, 1'b1, 32'h500);
      wait_req(5, 32'h504, 0, 4, 1'b1);
      halt(5, 1'b0);
      do_ack(5, 32'h4, 1'b0, 32'h0);

      // redirect of an in-flight fetch
      dispatch(7, 32'h200);
      wait_req(7, 32'h200, 0, 10, 1'b1);
      redirect(7, 32'h400);
      do_ack(7, 32'hDEAD_DEAD, 1'b0, 32'h0);
      wait_req(7, 32'h400, 0, 10, 1'b1);
      do_ack(7, 32'h7777_7777, 1'b1, 32'h400);
      wait_req(7, 32'h404, 0, 10, 1'b1);
      halt(7, 1'b0);
      do_ack(7, 32'h5, 1'b0, 32'h0);

      // halt together with ack
      dispatch(2, 32'h300);
      wait_req(2, 32'h300, 0, 10, 1'b1);
      halt(2, 1'b1);
      repeat (8) tick();
      chk("halt_no_req", 64'(fetch_req), 64'd0);
      do_ack(2, 32'h6, 1'b0, 32'h0);

      // PC wrap, then reset while a request is held
      dispatch(9, 32'hFFFF_FFFC);
      wait_req(9, 32'hFFFF_FFFC, 0, 10, 1'b1);
      do_ack(9, 32'hF9F9_F9F9, 1'b1, 32'hFFFF_FFFC);
      wait_req(9, 32'h0, 0, 10, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_req", 64'(fetch_req), 64'd0);
      chk("rst_async_q_wr", 64'(q_wr), 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      do_ack(9, 32'h9, 1'b0, 32'h0);
      repeat (5) tick();
      chk("post_rst_no_req", 64'(fetch_req), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
